// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serializer / deserializer family.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Counter width helper. $clog2 gives 0 for n <= 1, and a counter that
  // only ever holds 0 or 1 still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Modulo-DIV bit-period divider; flags the first and last clock of each period.
// Latency: flags are decodes of the counter register, valid in the same cycle.
// Backpressure: none; counts whenever run is high, clr has priority.
// Ports: clk, rst_n (async, active-low); clr restarts the period at 0;
//        run advances the counter; first = (count == 0); last = (count == DIV-1).
module bit_tick_gen
  import serdes_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic first,
  output logic last
);

  localparam int DW = clog2_min1(DIV);
  localparam logic [DW-1:0] LAST_CNT = DW'(DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  assign first = (cnt == '0);
  assign last  = (cnt == LAST_CNT);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: one WIDTH-bit word out as WIDTH strobed bits, DIV clocks each.
// Latency: word accepted at edge T shows its first bit and strobe during cycle T+1.
// Backpressure: in_ready low while shifting, except in the last clock of the last bit.
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready word handshake;
//        out_d/out_en serial bit and its one-clock strobe; busy while shifting;
//        done pulses for one cycle after the final bit period of a word.
module bit_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_d,
  output logic             out_en,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2_min1(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;
  logic             in_shift;
  logic             tick_first;
  logic             tick_last;
  logic             word_end;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign in_shift   = (state == SHIFT);
  assign word_end   = in_shift && tick_last && (bit_cnt == LAST_BIT);
  // Opening the handshake in the final clock lets the next word follow with no gap.
  assign in_ready   = !in_shift || word_end;
  assign accept     = in_valid && in_ready;
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .run   (in_shift),
    .first (tick_first),
    .last  (tick_last)
  );

  // Both are pure decodes of flops (state, divider), so they carry no
  // combinational path from the inputs.
  assign busy   = in_shift;
  assign out_en = in_shift && tick_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      out_d   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= word_end;
      if (accept) begin
        state   <= SHIFT;
        shreg   <= in_data;
        bit_cnt <= '0;
        out_d   <= head(in_data);
      end else if (in_shift && tick_last) begin
        shreg <= shreg_next;
        if (word_end) begin
          // out_d keeps the final bit while idle.
          state   <= IDLE;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          out_d   <= head(shreg_next);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  localparam int W  = 8;
  localparam int N  = 6000;
  localparam int NI = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] in_data  [NI];
  logic         in_valid [NI];
  logic         in_ready [NI];
  logic         out_d    [NI];
  logic         out_en   [NI];
  logic         busy     [NI];
  logic         done     [NI];
  logic         q0 = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected timeline per instance, indexed by cycle number.
  bit exp_busy [NI][N];
  bit exp_en   [NI][N];
  bit exp_d    [NI][N];
  bit exp_done [NI][N];
  // Observed DUT outputs, for the literal checks.
  bit log_en   [NI][N];
  bit log_d    [NI][N];
  bit log_done [NI][N];
  bit log_busy [NI][N];
  bit log_q    [N];
  int acc_cnt  [NI];
  int acc_cyc  [NI];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .DIV(4), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_d(out_d[0]), .out_en(out_en[0]), .busy(busy[0]), .done(done[0]));
  bit_serializer #(.WIDTH(W), .DIV(4), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_d(out_d[1]), .out_en(out_en[1]), .busy(busy[1]), .done(done[1]));
  bit_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_d(out_d[2]), .out_en(out_en[2]), .busy(busy[2]), .done(done[2]));

  // Downstream enabled D flop fed by u0.
  always @(posedge clk) if (out_en[0]) q0 <= out_d[0];

  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  // Ready when nothing is being sent, or when the current word's period ends this cycle.
  function automatic bit rdy_exp(input int i, input int n);
    if (n + 1 >= N) return !exp_busy[i][n];
    return !exp_busy[i][n] || exp_done[i][n+1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Word accepted at edge t: bit k occupies cycles t+1+k*DIV .. t+(k+1)*DIV.
  task automatic schedule(input int i, input int t, input logic [W-1:0] w);
    int dv, c, e;
    bit b;
    dv = div_of(i);
    e  = t + 1 + W * dv;
    if (e >= N) return;
    b = 1'b0;
    for (int k = 0; k < W; k++) begin
      b = msb_of(i) ? w[W-1-k] : w[k];
      for (int j = 0; j < dv; j++) begin
        c = t + 1 + k * dv + j;
        exp_busy[i][c] = 1'b1;
        exp_en[i][c]   = (j == 0);
        exp_d[i][c]    = b;
      end
    end
    exp_done[i][e] = 1'b1;
    for (int x = e; x < N; x++) exp_d[i][x] = b;
    acc_cyc[i] = t;
    acc_cnt[i]++;
  endtask

  task automatic model_clear(input int from);
    for (int i = 0; i < NI; i++)
      for (int c = from; c < N; c++) begin
        exp_busy[i][c] = 1'b0;
        exp_en[i][c]   = 1'b0;
        exp_d[i][c]    = 1'b0;
        exp_done[i][c] = 1'b0;
      end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      if (rst_n && in_valid[i] === 1'b1 && cyc < N && rdy_exp(i, cyc))
        schedule(i, cyc, in_data[i]);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc < N - 1) begin
      for (int i = 0; i < NI; i++) begin
        log_en[i][cyc]   = out_en[i];
        log_d[i][cyc]    = out_d[i];
        log_done[i][cyc] = done[i];
        log_busy[i][cyc] = busy[i];
        chk($sformatf("cycle%0d_u%0d_rdy_busy_en_d_done", cyc, i),
            {27'd0, in_ready[i], busy[i], out_en[i], out_d[i], done[i]},
            {27'd0, rdy_exp(i, cyc), exp_busy[i][cyc], exp_en[i][cyc], exp_d[i][cyc], exp_done[i][cyc]});
      end
      log_q[cyc] = q0;
    end
  end

  task automatic wait_acc(input int i, input int c0);
    int k;
    k = 0;
    while (acc_cnt[i] == c0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (acc_cnt[i] == c0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout_u%0d: no handshake in %0d cycles, required one", i, k);
    end
  endtask

  task automatic rand_drive(input int i);
    int c0, gap;
    for (int w = 0; w < 30; w++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      repeat (gap) begin
        in_valid[i] = 1'b0;
        in_data[i]  = W'($urandom);
        @(posedge clk); #1;
      end
      c0 = acc_cnt[i];
      in_valid[i] = 1'b1;
      in_data[i]  = W'($urandom);
      for (int k = 0; k < 300 && acc_cnt[i] == c0; k++) begin
        @(posedge clk); #1;
        if (acc_cnt[i] == c0 && $urandom_range(0, 1) == 1) in_data[i] = W'($urandom);
      end
      if (acc_cnt[i] == c0) begin
        tests++;
        fails++;
        $display("FAIL rand_accept_timeout_u%0d: no handshake, required one", i);
      end
    end
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #55000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int t, ta, tb2, cnt, c0;
    logic [7:0] lit;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      acc_cnt[i]  = 0;
      acc_cyc[i]  = 0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk($sformatf("idle_u%0d_rdy_en_busy_done", i),
            {28'd0, in_ready[i], out_en[i], busy[i], done[i]}, 32'b1000);
    end

    // 0xA5 on u0, 0x01 LSB-first on u1, 0x3C at DIV=1 on u2, all on one edge.
    c0 = acc_cnt[0];
    in_data[0] = 8'hA5; in_data[1] = 8'h01; in_data[2] = 8'h3C;
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b1;
    wait_acc(0, c0);
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
    t = acc_cyc[0];
    repeat (75) @(posedge clk);
    #1;
    lit = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("model_a5_bit%0d", k), exp_d[0][t+1+4*k], lit[7-k]);
      chk($sformatf("a5_strobe%0d", k), log_en[0][t+1+4*k], 1);
      chk($sformatf("a5_bit%0d", k), log_d[0][t+1+4*k], lit[7-k]);
      chk($sformatf("a5_q%0d", k), log_q[t+2+4*k], lit[7-k]);
      chk($sformatf("lsb01_strobe%0d", k), log_en[1][t+1+4*k], 1);
      chk($sformatf("lsb01_bit%0d", k), log_d[1][t+1+4*k], (k == 0));
    end
    cnt = 0;
    for (int c = t + 1; c <= t + 32; c++) cnt += int'(log_en[0][c]);
    chk("a5_strobe_count", cnt, 8);
    chk("a5_done_T33", log_done[0][t+33], 1);
    chk("a5_done_T32", log_done[0][t+32], 0);
    chk("a5_busy_T33", log_busy[0][t+33], 0);
    lit = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("div1_strobe%0d", k), log_en[2][t+1+k], 1);
      chk($sformatf("div1_bit%0d", k), log_d[2][t+1+k], lit[7-k]);
    end
    chk("div1_no_strobe_T9", log_en[2][t+9], 0);
    chk("div1_done_T9", log_done[2][t+9], 1);

    // Back-to-back 0xFF then 0x00 with valid held high.
    c0 = acc_cnt[0];
    in_data[0] = 8'hFF; in_valid[0] = 1'b1;
    wait_acc(0, c0);
    ta = acc_cyc[0];
    c0 = acc_cnt[0];
    in_data[0] = 8'h00;
    wait_acc(0, c0);
    tb2 = acc_cyc[0];
    in_valid[0] = 1'b0;
    chk("b2b_second_accept_offset", tb2 - ta, 32);
    repeat (40) @(posedge clk);
    #1;
    cnt = 0;
    for (int c = ta + 1; c <= ta + 64; c++) cnt += int'(log_busy[0][c]);
    chk("b2b_busy_cycles", cnt, 64);
    cnt = 0;
    for (int c = ta + 1; c <= ta + 64; c++) cnt += int'(log_en[0][c]);
    chk("b2b_strobe_count", cnt, 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("b2b_bit%0d", k), log_d[0][ta+1+4*k], (k < 8));
    cnt = 0;
    for (int c = ta + 1; c <= ta + 70; c++) cnt += int'(log_done[0][c]);
    chk("b2b_done_count", cnt, 2);
    chk("b2b_done_T33", log_done[0][ta+33], 1);
    chk("b2b_done_T65", log_done[0][ta+65], 1);

    // Reset in the middle of a word, after strobe 3.
    c0 = acc_cnt[0];
    in_data[0] = 8'hC3; in_valid[0] = 1'b1;
    wait_acc(0, c0);
    in_valid[0] = 1'b0;
    t = acc_cyc[0];
    while (cyc < t + 14) @(negedge clk);
    chk("midword_busy_before_reset", busy[0], 1);
    #2 rst_n = 1'b0;
    model_clear(cyc + 1);
    #1;
    chk("async_reset_rdy_busy_en_d_done",
        {27'd0, in_ready[0], busy[0], out_en[0], out_d[0], done[0]}, 32'b10000);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    cnt = 0;
    for (int c = t; c <= t + 45; c++) cnt += int'(log_done[0][c]);
    chk("no_done_after_reset", cnt, 0);

    c0 = acc_cnt[0];
    in_data[0] = 8'h81; in_valid[0] = 1'b1;
    wait_acc(0, c0);
    in_valid[0] = 1'b0;
    t = acc_cyc[0];
    repeat (40) @(posedge clk);
    #1;
    lit = 8'h81;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("post_reset_81_strobe%0d", k), log_en[0][t+1+4*k], 1);
      chk($sformatf("post_reset_81_bit%0d", k), log_d[0][t+1+4*k], lit[7-k]);
    end
    chk("post_reset_81_done", log_done[0][t+33], 1);

    // Randomized traffic on all three instances.
    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
    join
    repeat (50) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
